term_resolve_unit: RTL and testbench
====================================

// Module: term_resolve_unit
// PURPOSE
//  Sink for terminate_pipeline results. Buffers resolved terminates (taken or failed) in a small FIFO.
//  Taken: fetch redirect, then ROB completion with dest-reg mapping. Failed: ROB completion only, no redirect.
//  Sits between the terminate execution pipeline and the fetch/ROB commit logic.
// PARAMETERS
//  DEPTH      4   FIFO entries (power of 2, >=2)
//  ADDR_W    16   redirect address width
//  ROB_W      5   ROB index width
// PORTS
//  clk              in   1       clock
//  rst              in   1       synchronous, active-high reset
//  result_addr      in   ADDR_W  target address from pipeline
//  result_valid     in   1       taken terminate present (implies result_ready was high)
//  term_failed      in   1       failed terminate present (implies result_ready was high)
//  result_ready     out  1       = !full; registered-state only, never depends on result_valid/term_failed
//  rob_entry_in     in   ROB_W   ROB index of the terminate
//  arch_dest_in     in   8       packed arch dest regs (zero when failed)
//  phys_dest_in     in   10      packed phys dest regs (zero when failed)
//  flush            in   1       pipeline flush; drop all buffered state
//  redir_valid      out  1       fetch redirect request
//  redir_addr       out  ADDR_W  redirect target
//  redir_ready      in   1       fetch accepts redirect
//  done_valid       out  1       ROB completion request
//  done_rob         out  ROB_W   ROB index completed
//  done_taken       out  1       1 = taken, 0 = failed/fall-through
//  done_arch        out  8       arch dest regs (0 when failed)
//  done_phys        out  10      phys dest regs (0 when failed)
//  done_ready       in   1       ROB accepts completion
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, result_ready=1, redir_valid=0, done_valid=0, all data outputs 0.
//  Push: when result_valid|term_failed; store {addr, rob, arch, phys, taken=result_valid}. Both high -> push once, taken=1.
//  Push while full impossible by contract; bench asserts it never happens.
//  FSM on FIFO head (all outputs registered):
//   IDLE: head present & taken -> REDIR; head present & failed -> DONE.
//   REDIR: redir_valid=1 with head addr; on redir_ready -> DONE.
//   DONE: done_valid=1 with head fields; on done_ready -> pop; IDLE.
//  Redirect always precedes completion for the same entry; entries complete strictly in FIFO order.
//  Minimum latency push -> redir_valid: 2 cycles (push cycle, IDLE cycle). Back-to-back entries: >=2 cycles each.
//  Simultaneous push and pop: allowed, count unchanged; full with pop same cycle still deasserts result_ready (no bypass).
//  Pointers wrap mod DEPTH; count is $clog2(DEPTH)+1 bits.
//  flush: next cycle FIFO empty, state IDLE, redir_valid=0, done_valid=0; a push in the flush cycle is dropped.
//  flush overrides handshakes in the same cycle (redir_ready/done_ready ignored).
//  rst mid-operation: identical to reset, all state discarded.
//  valid outputs stay high and data stable until accepted (AXI-style; no withdraw except on flush/rst).
// CONFIGURATION
//  TERM_RESOLVE_STATS_EN defined: adds outputs stat_taken[15:0], stat_failed[15:0]; increment on each pop
//   by taken flag, saturate at 16'hFFFF; cleared by rst only, not by flush.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package (term_pkg): term_entry_t struct {addr, rob, arch, phys, taken}; FSM state enum
//   {ST_IDLE, ST_REDIR, ST_DONE}; ARCH_DEST_W=8, PHYS_DEST_W=10 constants.
//  One sub-module: term_fifo (parameterised sync FIFO of term_entry_t, push/pop/full/empty/flush).
//  FSM and stats counters in top level.
// TESTING
//  1. Reset, then idle: result_ready=1, redir_valid=0, done_valid=0 for 10 cycles.
//  2. Taken push addr=16'h1234 rob=5 arch=8'h21 phys=10'h0A3, redir_ready=done_ready=1 -> redir_addr=1234 then
//     done rob=5 taken=1 arch=21 phys=0A3; FIFO empty after.
//  3. Failed push rob=7 -> no redir_valid; done_valid with rob=7 taken=0 arch=0 phys=0.
//  4. 5 pushes, redir_ready=0 -> result_ready low after 4th; release stalls -> completions in order rob 1..4.
//  5. 3 entries buffered, redir_valid high, pulse flush -> next cycle redir_valid=0, empty, result_ready=1; no done issued.
//  6. With TERM_RESOLVE_STATS_EN: 3 taken + 2 failed completed -> stat_taken=3, stat_failed=2; flush keeps values.

Source files
------------

// File: rtl/term_pkg.sv
// term_pkg: shared entry layout, FSM states and dest-reg widths for the terminate resolve unit.
package term_pkg;
    localparam int TERM_ADDR_W = 16;
    localparam int TERM_ROB_W  = 5;
    localparam int ARCH_DEST_W = 8;
    localparam int PHYS_DEST_W = 10;

    typedef struct packed {
        logic [TERM_ADDR_W-1:0] addr;
        logic [TERM_ROB_W-1:0]  rob;
        logic [ARCH_DEST_W-1:0] arch;
        logic [PHYS_DEST_W-1:0] phys;
        logic                   taken;
    } term_entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_REDIR, ST_DONE} term_state_t;
endpackage

// File: rtl/term_fifo.sv
// term_fifo: synchronous FIFO of term_entry_t with flush; head is read combinationally.
module term_fifo
    import term_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  term_entry_t din,
    output term_entry_t head,
    output logic        full,
    output logic        empty
);
    localparam int PW = $clog2(DEPTH);

    term_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push && !flush;
        do_pop  = pop && !flush && !empty;
        wr_d    = flush ? '0 : wr_q + PW'(do_push);
        rd_d    = flush ? '0 : rd_q + PW'(do_pop);
        cnt_d   = flush ? '0 : cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    assign head  = mem_q[rd_q];
    assign full  = cnt_q == (PW+1)'(DEPTH);
    assign empty = cnt_q == '0;
endmodule

// File: rtl/term_resolve_unit.sv
// term_resolve_unit: buffers resolved terminates, issues fetch redirect (taken) then ROB completion.
// Optional TERM_RESOLVE_STATS_EN adds saturating taken/failed completion counters.
module term_resolve_unit
    import term_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int ROB_W  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      result_addr,
    input  logic                   result_valid,
    input  logic                   term_failed,
    output logic                   result_ready,
    input  logic [ROB_W-1:0]       rob_entry_in,
    input  logic [ARCH_DEST_W-1:0] arch_dest_in,
    input  logic [PHYS_DEST_W-1:0] phys_dest_in,
    input  logic                   flush,
    output logic                   redir_valid,
    output logic [ADDR_W-1:0]      redir_addr,
    input  logic                   redir_ready,
    output logic                   done_valid,
    output logic [ROB_W-1:0]       done_rob,
    output logic                   done_taken,
    output logic [ARCH_DEST_W-1:0] done_arch,
    output logic [PHYS_DEST_W-1:0] done_phys,
`ifdef TERM_RESOLVE_STATS_EN
    output logic [15:0]            stat_taken,
    output logic [15:0]            stat_failed,
`endif
    input  logic                   done_ready
);
    term_entry_t in_e, head;
    logic        full, empty, pop;

    term_state_t            state_q, state_d;
    logic                   redir_valid_q, redir_valid_d;
    logic [ADDR_W-1:0]      redir_addr_q, redir_addr_d;
    logic                   done_valid_q, done_valid_d;
    logic [ROB_W-1:0]       done_rob_q, done_rob_d;
    logic                   done_taken_q, done_taken_d;
    logic [ARCH_DEST_W-1:0] done_arch_q, done_arch_d;
    logic [PHYS_DEST_W-1:0] done_phys_q, done_phys_d;

    always_comb begin
        in_e.addr  = result_addr;
        in_e.rob   = rob_entry_in;
        in_e.arch  = arch_dest_in;
        in_e.phys  = phys_dest_in;
        in_e.taken = result_valid;
    end

    term_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (result_valid | term_failed),
        .pop   (pop),
        .din   (in_e),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Completion fields are latched when the head is first seen and held until popped.
    always_comb begin
        state_d       = state_q;
        redir_valid_d = redir_valid_q;
        redir_addr_d  = redir_addr_q;
        done_valid_d  = done_valid_q;
        done_rob_d    = done_rob_q;
        done_taken_d  = done_taken_q;
        done_arch_d   = done_arch_q;
        done_phys_d   = done_phys_q;
        pop           = 1'b0;
        if (flush) begin
            state_d       = ST_IDLE;
            redir_valid_d = 1'b0;
            done_valid_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (!empty) begin
                    state_d       = head.taken ? ST_REDIR : ST_DONE;
                    redir_valid_d = head.taken;
                    redir_addr_d  = head.addr;
                    done_valid_d  = !head.taken;
                    done_rob_d    = head.rob;
                    done_taken_d  = head.taken;
                    done_arch_d   = head.taken ? head.arch : '0;
                    done_phys_d   = head.taken ? head.phys : '0;
                end
                ST_REDIR: if (redir_ready) begin
                    state_d       = ST_DONE;
                    redir_valid_d = 1'b0;
                    done_valid_d  = 1'b1;
                end
                ST_DONE: if (done_ready) begin
                    pop          = 1'b1;
                    state_d      = ST_IDLE;
                    done_valid_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            redir_valid_q <= 1'b0;
            redir_addr_q  <= '0;
            done_valid_q  <= 1'b0;
            done_rob_q    <= '0;
            done_taken_q  <= 1'b0;
            done_arch_q   <= '0;
            done_phys_q   <= '0;
        end else begin
            state_q       <= state_d;
            redir_valid_q <= redir_valid_d;
            redir_addr_q  <= redir_addr_d;
            done_valid_q  <= done_valid_d;
            done_rob_q    <= done_rob_d;
            done_taken_q  <= done_taken_d;
            done_arch_q   <= done_arch_d;
            done_phys_q   <= done_phys_d;
        end
    end

    assign result_ready = !full;
    assign redir_valid  = redir_valid_q;
    assign redir_addr   = redir_addr_q;
    assign done_valid   = done_valid_q;
    assign done_rob     = done_rob_q;
    assign done_taken   = done_taken_q;
    assign done_arch    = done_arch_q;
    assign done_phys    = done_phys_q;

`ifdef TERM_RESOLVE_STATS_EN
    logic [15:0] stat_taken_q, stat_taken_d, stat_failed_q, stat_failed_d;

    always_comb begin
        stat_taken_d  = (pop && head.taken && stat_taken_q != '1) ? stat_taken_q + 16'd1 : stat_taken_q;
        stat_failed_d = (pop && !head.taken && stat_failed_q != '1) ? stat_failed_q + 16'd1 : stat_failed_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_taken_q  <= '0;
            stat_failed_q <= '0;
        end else begin
            stat_taken_q  <= stat_taken_d;
            stat_failed_q <= stat_failed_d;
        end
    end

    assign stat_taken  = stat_taken_q;
    assign stat_failed = stat_failed_q;
`endif
endmodule

// File: tb/tb_term_resolve_unit.sv
// tb_term_resolve_unit: directed and randomized checks against a queue-based model of the resolve unit.
module tb_term_resolve_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic        rv = 1'b0, tf = 1'b0, rr = 1'b0, dr = 1'b0, fl = 1'b0;
    logic [4:0]  rob = '0;
    logic [7:0]  arch = '0;
    logic [9:0]  phys = '0;

    logic        result_ready, redir_valid, done_valid, done_taken;
    logic [15:0] redir_addr;
    logic [4:0]  done_rob;
    logic [7:0]  done_arch;
    logic [9:0]  done_phys;
`ifdef TERM_RESOLVE_STATS_EN
    logic [15:0] stat_taken, stat_failed;
`endif

    always #5 clk = ~clk;

    term_resolve_unit #(.DEPTH(DEPTH), .ADDR_W(16), .ROB_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .result_addr  (addr),
        .result_valid (rv),
        .term_failed  (tf),
        .result_ready (result_ready),
        .rob_entry_in (rob),
        .arch_dest_in (arch),
        .phys_dest_in (phys),
        .flush        (fl),
        .redir_valid  (redir_valid),
        .redir_addr   (redir_addr),
        .redir_ready  (rr),
        .done_valid   (done_valid),
        .done_rob     (done_rob),
        .done_taken   (done_taken),
        .done_arch    (done_arch),
        .done_phys    (done_phys),
`ifdef TERM_RESOLVE_STATS_EN
        .stat_taken   (stat_taken),
        .stat_failed  (stat_failed),
`endif
        .done_ready   (dr)
    );

    typedef struct {
        logic [15:0] addr;
        logic [4:0]  rob;
        logic [7:0]  arch;
        logic [9:0]  phys;
        bit          taken;
        bit          red;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0, n_fail = 0;
    int   n_taken = 0, n_failed = 0, n_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Check outputs against the model, advance the model across the coming edge, then clear pulses.
    task automatic step();
        ent_t e;
        @(negedge clk);
        check("ready", result_ready, q.size() < DEPTH);
        check("one_valid", redir_valid & done_valid, 0);
        if (redir_valid) begin
            if (q.size() > 0) begin
                check("redir_front", q[0].taken && !q[0].red, 1);
                check("redir_addr", redir_addr, q[0].addr);
            end else check("redir_empty", redir_valid, 0);
        end
        if (done_valid) begin
            if (q.size() > 0) begin
                check("done_front", !q[0].taken || q[0].red, 1);
                check("done_rob", done_rob, q[0].rob);
                check("done_taken", done_taken, q[0].taken);
                check("done_arch", done_arch, q[0].taken ? q[0].arch : 8'h0);
                check("done_phys", done_phys, q[0].taken ? q[0].phys : 10'h0);
            end else check("done_empty", done_valid, 0);
        end
`ifdef TERM_RESOLVE_STATS_EN
        check("stat_taken", stat_taken, n_taken);
        check("stat_failed", stat_failed, n_failed);
`endif
        if (rst) begin
            q.delete();
            n_taken = 0;
            n_failed = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (redir_valid && rr && q.size() > 0) q[0].red = 1'b1;
            if (done_valid && dr && q.size() > 0) begin
                if (q[0].taken) n_taken++;
                else n_failed++;
                n_done++;
                void'(q.pop_front());
            end
            if (rv | tf) begin
                check("push_room", result_ready, 1);
                e.addr = addr;
                e.rob = rob;
                e.arch = arch;
                e.phys = phys;
                e.taken = rv;
                e.red = 1'b0;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        rv = 1'b0;
        tf = 1'b0;
        fl = 1'b0;
    endtask

    initial begin
        int base;
        int kind;
        step();
        step();
        rst = 1'b0;

        check("rst_redir_addr", redir_addr, 0);
        check("rst_done_rob", done_rob, 0);
        check("rst_done_arch", done_arch, 0);
        check("rst_done_phys", done_phys, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_ready", result_ready, 1);
            check("idle_redir", redir_valid, 0);
            check("idle_done", done_valid, 0);
        end

        rr = 1'b1;
        dr = 1'b1;
        addr = 16'h1234; rob = 5'd5; arch = 8'h21; phys = 10'h0A3; rv = 1'b1;
        step();
        check("t2_idle_cycle", redir_valid, 0);
        step();
        check("t2_redir_valid", redir_valid, 1);
        check("t2_redir_addr", redir_addr, 16'h1234);
        step();
        check("t2_done_valid", done_valid, 1);
        check("t2_done_rob", done_rob, 5);
        check("t2_done_taken", done_taken, 1);
        check("t2_done_arch", done_arch, 8'h21);
        check("t2_done_phys", done_phys, 10'h0A3);
        step();
        check("t2_done_clear", done_valid, 0);
        check("t2_ready", result_ready, 1);

        addr = 16'hBEEF; rob = 5'd7; arch = '0; phys = '0; tf = 1'b1;
        step();
        step();
        check("t3_no_redir", redir_valid, 0);
        check("t3_done_valid", done_valid, 1);
        check("t3_done_rob", done_rob, 7);
        check("t3_done_taken", done_taken, 0);
        check("t3_done_arch", done_arch, 0);
        check("t3_done_phys", done_phys, 0);
        step();
        check("t3_done_clear", done_valid, 0);

        rr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            addr = 16'h0100 + 16'(i); rob = 5'(i); arch = 8'(i); phys = 10'(i); rv = 1'b1;
            step();
            check("t4_ready", result_ready, i < 4);
        end
        check("t4_fifth_blocked", result_ready, 0);
        rr = 1'b1;
        base = n_done;
        for (int i = 0; i < 60 && n_done - base < 4; i++) step();
        check("t4_completions", n_done - base, 4);

        rr = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            addr = 16'h0200 + 16'(i); rob = 5'(i + 10); arch = 8'h33; phys = 10'h155; rv = 1'b1;
            step();
        end
        for (int i = 0; i < 10 && !redir_valid; i++) step();
        check("t5_redir_before", redir_valid, 1);
        fl = 1'b1;
        addr = 16'hDEAD; rob = 5'd9; rv = 1'b1;
        step();
        check("t5_redir_flushed", redir_valid, 0);
        check("t5_done_flushed", done_valid, 0);
        check("t5_ready", result_ready, 1);
        rr = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("t5_quiet", redir_valid | done_valid, 0);

`ifdef TERM_RESOLVE_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            addr = 16'(16'h0300 + i); rob = 5'(i); rv = i < 3; tf = i >= 3;
            arch = (i < 3) ? 8'h11 : 8'h0; phys = (i < 3) ? 10'h22 : 10'h0;
            step();
            for (int k = 0; k < 5; k++) step();
        end
        check("t6_taken", stat_taken, 3);
        check("t6_failed", stat_failed, 2);
        fl = 1'b1;
        step();
        check("t6_taken_flush", stat_taken, 3);
        check("t6_failed_flush", stat_failed, 2);
`endif

        for (int c = 0; c < 3000; c++) begin
            rr = $urandom_range(0, 3) != 0;
            dr = $urandom_range(0, 3) != 0;
            fl = $urandom_range(0, 59) == 0;
            rst = $urandom_range(0, 799) == 0;
            if (result_ready && $urandom_range(0, 1) == 1) begin
                kind = $urandom_range(0, 2);
                rv = kind != 1;
                tf = kind != 0;
                addr = 16'($urandom);
                rob = 5'($urandom);
                arch = rv ? 8'($urandom) : 8'h0;
                phys = rv ? 10'($urandom) : 10'h0;
            end
            step();
        end
        rst = 1'b0;
        rr = 1'b1;
        dr = 1'b1;
        for (int i = 0; i < 100 && q.size() > 0; i++) step();
        check("drain_empty", q.size(), 0);
        step();
        check("drain_ready", result_ready, 1);
        check("drain_quiet", redir_valid | done_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
